ysyx_imem_rsp: RTL and testbench

YSYX_IMEM_RSP -- requirements
Module: ysyx_imem_rsp

---
 rtl/ysyx_imem_rsp.sv | 147 ++++++++++++++
 tb/tb_ysyx_imem_rsp.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_imem_rsp.sv
// ysyx_imem_rsp: instruction-memory responder for the fetch unit.
// Accepts one read at a time, answers after a fixed LATENCY with data from an
// internal word array (or SLVERR for unmapped/misaligned addresses), and
// offers a backdoor write port for program loading.
module ysyx_imem_rsp #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MEM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rvalid,
  output logic [1:0]        ifu_rresp,
  output logic              busy,
  input  logic              ld_wen,
  input  logic [ADDR_W-1:0] ld_waddr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [31:0]       rd_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int IDX_W = $clog2(MEM_DEPTH);
  // Counter only ever holds LATENCY-1 down to 1.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(4 * MEM_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rd_ok_q, rd_ok_d;
  logic [31:0]       rd_count_q, rd_count_d;
  logic [DATA_W-1:0] mem_rd_q;
  logic              enter_resp;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Address decode. Offsets are taken modulo 2^ADDR_W so that anything below
  // BASE_ADDR wraps to a huge offset and falls outside the span.
  logic [ADDR_W-1:0] resp_addr;
  logic [ADDR_W-1:0] rd_off;
  logic [ADDR_W-1:0] wr_off;
  logic              rd_ok;
  logic              wr_ok;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;

  // With LATENCY=1 the array is read on the accepting edge, so the live
  // request address is used instead of the captured one.
  assign resp_addr = (state_q == S_IDLE) ? ifu_araddr : addr_q;
  assign rd_off    = resp_addr - BASE_ADDR;
  assign wr_off    = ld_waddr - BASE_ADDR;
  assign rd_ok     = (rd_off < SPAN) && (rd_off[1:0] == 2'b00);
  assign wr_ok     = (wr_off < SPAN) && (wr_off[1:0] == 2'b00);
  assign rd_idx    = rd_off[IDX_W+1:2];
  assign wr_idx    = wr_off[IDX_W+1:2];

  // Next-state logic: accept in IDLE, count down in WAIT, single-cycle RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rresp_d    = rresp_q;
    rd_ok_d    = rd_ok_q;
    rd_count_d = rd_count_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ifu_arvalid) begin
          addr_d = ifu_araddr;
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        state_d    = S_IDLE;
        rd_count_d = rd_count_q + 32'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      rd_ok_d = rd_ok;
      rresp_d = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rresp_q    <= RESP_OKAY;
      rd_ok_q    <= 1'b0;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rresp_q    <= rresp_d;
      rd_ok_q    <= rd_ok_d;
      rd_count_q <= rd_count_d;
    end
  end

  // Word array: backdoor write plus registered read on the edge entering RESP.
  // Contents survive reset; a write on the read edge returns the old word.
  always_ff @(posedge clk) begin
    if (rst && ld_wen && wr_ok) begin
      mem[wr_idx] <= ld_wdata;
    end
    if (enter_resp) begin
      mem_rd_q <= mem[rd_idx];
    end
  end

  assign ifu_rdata  = rd_ok_q ? mem_rd_q : '0;
  assign ifu_rresp  = rresp_q;
  assign ifu_rvalid = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign rd_count   = rd_count_q;

endmodule

// File: tb/tb_ysyx_imem_rsp.sv
// Testbench for ysyx_imem_rsp: directed and randomized fetches checked against
// a word-array reference model and a response-timing rule.
module tb_ysyx_imem_rsp;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic [31:0] ifu_rdata;
  logic        ifu_rvalid;
  logic [1:0]  ifu_rresp;
  logic        busy;
  logic        ld_wen;
  logic [31:0] ld_waddr;
  logic [31:0] ld_wdata;
  logic [31:0] rd_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  logic [31:0] model [0:DEPTH-1];

  ysyx_imem_rsp #(
    .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
    .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid), .ifu_rresp(ifu_rresp),
    .busy(busy),
    .ld_wen(ld_wen), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
    .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH)) && (a[1:0] == 2'b00);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    if (in_range(a)) model[widx(a)] = d;
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] d);
    ld_wen = 1'b1; ld_waddr = a; ld_wdata = d;
    tick();
    ld_wen = 1'b0;
    model_write(a, d);
  endtask

  // One fetch. drop: release arvalid and scramble the address after accept.
  // wr_edge: edge (0 = accepting edge) carrying a backdoor write, -1 for none.
  task automatic txn(input logic [31:0] a, input bit drop, input int wr_edge,
                     input logic [31:0] wa, input logic [31:0] wd, input string tag);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    exp_d = '0;
    exp_r = 2'b10;
    for (int e = 0; e < LAT; e++) begin
      if (e == 0 || !drop) begin
        ifu_arvalid = 1'b1; ifu_araddr = a;
      end else begin
        ifu_arvalid = 1'b0; ifu_araddr = $urandom;
      end
      ld_wen = (e == wr_edge); ld_waddr = wa; ld_wdata = wd;
      if (e == LAT - 1) begin
        // Response reflects memory as it stood before the edge entering RESP.
        exp_d = in_range(a) ? model[widx(a)] : 32'h0;
        exp_r = in_range(a) ? 2'b00 : 2'b10;
      end
      tick();
      if (e == wr_edge) model_write(wa, wd);
      ld_wen = 1'b0;
      if (e < LAT - 1) begin
        chk({tag, "_early_rvalid"}, ifu_rvalid, 1'b0);
        chk({tag, "_wait_busy"}, busy, 1'b1);
      end
    end
    ifu_arvalid = 1'b0;
    chk({tag, "_rvalid"}, ifu_rvalid, 1'b1);
    chk({tag, "_rdata"}, ifu_rdata, exp_d);
    chk({tag, "_rresp"}, ifu_rresp, exp_r);
    chk({tag, "_resp_busy"}, busy, 1'b1);
    chk({tag, "_cnt_in_resp"}, rd_count, exp_count);
    $display("txn %s addr=%h rresp=%0h rdata=%h", tag, a, ifu_rresp, ifu_rdata);
    tick();
    exp_count++;
    chk({tag, "_rvalid_off"}, ifu_rvalid, 1'b0);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_rd_count"}, rd_count, exp_count);
    if (drop) begin
      tick();
      chk({tag, "_no_repeat"}, ifu_rvalid, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] wa;
    logic [31:0] exp_d;
    int          wr_edge;

    rst = 1'b0; ifu_araddr = BASE; ifu_arvalid = 1'b1;
    ld_wen = 1'b0; ld_waddr = '0; ld_wdata = '0;
    repeat (3) tick();
    chk("rst_rvalid", ifu_rvalid, 1'b0);
    chk("rst_rdata", ifu_rdata, 32'h0);
    chk("rst_rresp", ifu_rresp, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_count", rd_count, 32'h0);
    ifu_arvalid = 1'b0;
    rst = 1'b1;
    tick();
    chk("idle_busy", busy, 1'b0);

    // Preload, then probe that unmapped/misaligned backdoor writes are dropped.
    for (int i = 0; i < DEPTH; i++) ld(BASE + 32'(4 * i), $urandom);
    ld(BASE, 32'h0000_0413);
    ld(32'h8000_1000, 32'hFFFF_FFFF);
    ld(32'h8000_0001, 32'hFFFF_FFFF);
    ld(32'h7FFF_FFFC, 32'hFFFF_FFFF);

    txn(BASE, 1'b0, -1, '0, '0, "first_fetch");
    chk("first_fetch_cnt1", rd_count, 32'd1);
    txn(32'h7FFF_FFFC, 1'b0, -1, '0, '0, "below_base");
    txn(32'h8000_0002, 1'b0, -1, '0, '0, "misaligned");
    txn(32'h8000_1000, 1'b0, -1, '0, '0, "above_top");
    txn(BASE + 32'(4 * (DEPTH - 1)), 1'b0, -1, '0, '0, "last_word");

    // Address change and arvalid drop while waiting.
    txn(BASE + 32'h40, 1'b1, -1, '0, '0, "drop_in_wait");

    // Back-to-back requests with arvalid held high.
    a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    exp_d = model[widx(a)];
    ifu_araddr = a; ifu_arvalid = 1'b1;
    tick();
    for (int k = 0; k < 3 * (LAT + 1); k++) begin
      chk("hold_rvalid", ifu_rvalid, 1'((k % (LAT + 1)) == LAT - 1));
      chk("hold_busy", busy, 1'((k % (LAT + 1)) != LAT));
      if ((k % (LAT + 1)) == LAT - 1) begin
        chk("hold_rdata", ifu_rdata, exp_d);
        $display("txn hold addr=%h rdata=%h", a, ifu_rdata);
      end
      if (k == 3 * (LAT + 1) - 1) ifu_arvalid = 1'b0;
      tick();
    end
    exp_count += 3;
    chk("hold_rd_count", rd_count, exp_count);

    // Backdoor write racing the read: same edge as entering RESP, then one earlier.
    chk("same_edge_old_differs", 1'(model[5] != 32'hDEAD_BEEF), 1'b1);
    txn(BASE + 32'h14, 1'b0, LAT - 1, BASE + 32'h14, 32'hDEAD_BEEF, "wr_same_edge");
    txn(BASE + 32'h14, 1'b0, -1, '0, '0, "wr_same_edge_after");
    txn(BASE + 32'h18, 1'b0, LAT - 2, BASE + 32'h18, 32'hDEAD_BEEF, "wr_edge_before");

    // Randomized fetches with random aborts-of-arvalid and racing writes.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      wr_edge = int'($urandom_range(0, LAT)) - 1;
      wa = ($urandom_range(0, 1) == 1) ? a : BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      txn(a, 1'($urandom_range(0, 1)), wr_edge, wa, $urandom, "rand");
    end

    // Reset pulse during WAIT aborts the request; backdoor write is ignored.
    a = BASE + 32'h80;
    ifu_araddr = a; ifu_arvalid = 1'b1;
    tick();
    ifu_arvalid = 1'b0;
    rst = 1'b0;
    ld_wen = 1'b1; ld_waddr = a; ld_wdata = ~model[widx(a)];
    tick();
    rst = 1'b1; ld_wen = 1'b0;
    exp_count = 0;
    chk("abort_rvalid", ifu_rvalid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rd_count", rd_count, 32'h0);
    chk("abort_rdata", ifu_rdata, 32'h0);
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      chk("abort_no_rvalid", ifu_rvalid, 1'b0);
    end
    txn(a, 1'b0, -1, '0, '0, "after_abort");
    chk("after_abort_cnt1", rd_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
